// File: rtl/bit_counter_pipe_stream.sv
// Stallable pipelined population counter: each stage adds one CHUNK-bit slice of the word.
// Optional BIT_COUNTER_PIPE_STATS_EN adds a saturating count of completed output beats (beats_o).
module bit_counter_pipe_stream #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   mode_i,
   input  logic                   data_val_i,
   output logic                   data_ready_o,
   output logic [WIDTH-1:0]       data_o,
   output logic                   mode_o,
   output logic [$clog2(WIDTH):0] count_o,
   output logic                   data_val_o,
`ifdef BIT_COUNTER_PIPE_STATS_EN
   output logic [31:0]            beats_o,
`endif
   input  logic                   data_ready_i
);

   localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
   localparam int CW    = $clog2(WIDTH) + 1;

   // Handshake: a beat moves across an interface on a rising edge where valid and
   // ready are both 1; the sender holds the beat stable until then, and ready
   // never depends combinationally on the valid of the same interface.
   logic [STAGES-1:0] val;
   logic [STAGES-1:0] adv;

   // A stage may advance when it, or any stage downstream of it, is a bubble,
   // or when the consumer takes the output beat.
   always_comb begin
      logic room;
      room = data_ready_i;
      adv  = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         room   = room | ~val[s];
         adv[s] = room;
      end
   end

   assign data_ready_o = rst_n_i & adv[0];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      // Slice mask is all zero for stages that start at or beyond WIDTH.
      localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - CHUNK)) << (s * CHUNK);

      logic             up_val;
      logic [WIDTH-1:0] up_data;
      logic             up_mode;
      logic [CW-1:0]    up_cnt;
      logic [CW-1:0]    slice_cnt;

      logic             val_q;
      logic [WIDTH-1:0] data_q;
      logic             mode_q;
      logic [CW-1:0]    cnt_q;

      if (s == 0) begin : g_head
         assign up_val  = data_val_i;
         assign up_data = data_i;
         assign up_mode = mode_i;
         assign up_cnt  = '0;
      end else begin : g_body
         assign up_val  = g_stage[s-1].val_q;
         assign up_data = g_stage[s-1].data_q;
         assign up_mode = g_stage[s-1].mode_q;
         assign up_cnt  = g_stage[s-1].cnt_q;
      end

      // Bits equal to ~mode are exactly the ones set in data ^ {mode}.
      assign slice_cnt = CW'($countones((up_data ^ {WIDTH{up_mode}}) & MASK));

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            val_q  <= 1'b0;
            data_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
         end else if (adv[s]) begin
            val_q <= up_val;
            if (up_val) begin
               data_q <= up_data;
               mode_q <= up_mode;
               cnt_q  <= up_cnt + slice_cnt;
            end
         end
      end

      assign val[s] = val_q;
   end

   assign data_o     = g_stage[STAGES-1].data_q;
   assign mode_o     = g_stage[STAGES-1].mode_q;
   assign count_o    = g_stage[STAGES-1].cnt_q;
   assign data_val_o = g_stage[STAGES-1].val_q;

`ifdef BIT_COUNTER_PIPE_STATS_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         beats_o <= '0;
      end else if (data_val_o && data_ready_i && (beats_o != 32'hFFFF_FFFF)) begin
         beats_o <= beats_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bit_counter_pipe_stream.sv
// Directed bench for bit_counter_pipe_stream: 16/4 main instance plus 10/4 and 10/1 slicing instances.
module tb_bit_counter_pipe_stream;

   localparam int W   = 16;
   localparam int CW  = 5;
   localparam int EW  = 1 + CW + W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // main instance
   logic [W-1:0]  data_in;
   logic          mode_in;
   logic          val_in;
   logic          rdy_out;
   logic [W-1:0]  dout;
   logic          mode_out;
   logic [CW-1:0] cnt_out;
   logic          vout;
   logic          rdy_in;

   // WIDTH=10, STAGES=4
   logic [9:0] d10, do10;
   logic       m10, v10, r10, mo10, vo10, ri10;
   logic [4:0] c10;

   // WIDTH=10, STAGES=1
   logic [9:0] ds1, dos1;
   logic       ms1, vs1, rs1, mos1, vos1, ris1;
   logic [4:0] cs1;

`ifdef BIT_COUNTER_PIPE_STATS_EN
   logic [31:0] beats, beats10, beats1;
`endif

   bit_counter_pipe_stream u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data_in), .mode_i(mode_in),
      .data_val_i(val_in), .data_ready_o(rdy_out), .data_o(dout), .mode_o(mode_out),
      .count_o(cnt_out), .data_val_o(vout),
`ifdef BIT_COUNTER_PIPE_STATS_EN
      .beats_o(beats),
`endif
      .data_ready_i(rdy_in)
   );

   bit_counter_pipe_stream #(.WIDTH(10), .STAGES(4)) u_w10 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(d10), .mode_i(m10),
      .data_val_i(v10), .data_ready_o(r10), .data_o(do10), .mode_o(mo10),
      .count_o(c10), .data_val_o(vo10),
`ifdef BIT_COUNTER_PIPE_STATS_EN
      .beats_o(beats10),
`endif
      .data_ready_i(ri10)
   );

   bit_counter_pipe_stream #(.WIDTH(10), .STAGES(1)) u_s1 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(ds1), .mode_i(ms1),
      .data_val_i(vs1), .data_ready_o(rs1), .data_o(dos1), .mode_o(mos1),
      .count_o(cs1), .data_val_o(vos1),
`ifdef BIT_COUNTER_PIPE_STATS_EN
      .beats_o(beats1),
`endif
      .data_ready_i(ris1)
   );

   // ---------------- scoreboard state ----------------
   int vectors     = 0;
   int miscompares = 0;
   int emitted     = 0;
   int em_base     = 0;
   logic [EW-1:0] exp_q[$];
   logic [CW-1:0] cur_exp;

   logic [W-1:0]  s_w [6] = '{16'hFFFF, 16'h0000, 16'h8001, 16'h1234, 16'hFFFF, 16'hAAAA};
   logic          s_m [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [CW-1:0] s_c [6] = '{5'd16, 5'd0, 5'd2, 5'd5, 5'd0, 5'd8};

   logic [W-1:0]  bp_w [9] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F,
                               16'h003F, 16'h007F, 16'h00FF, 16'hFFFF};
   logic          bp_m [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [CW-1:0] bp_c [9] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10, 5'd7, 5'd8, 5'd16};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [W-1:0] d, input logic m, input logic [CW-1:0] c);
      val_in  = v;
      data_in = d;
      mode_in = m;
      cur_exp = c;
   endtask

   // One clock: handshakes are observed mid-cycle, then time moves to just after the edge.
   task automatic step();
      logic [EW-1:0] e;
      @(negedge clk);
      if (val_in && rdy_out) exp_q.push_back({mode_in, cur_exp, data_in});
      if (vout && rdy_in) begin
         emitted++;
         check("out_beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_beat", 32'({mode_out, cnt_out, dout}), 32'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int  idx;
      int  n;
      logic took;
      logic v;

      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0, '0);
      rdy_in = 1'b1;
      d10 = '0; m10 = 1'b0; v10 = 1'b0; ri10 = 1'b1;
      ds1 = '0; ms1 = 1'b0; vs1 = 1'b0; ris1 = 1'b1;
      #1 rst_n = 1'b0;
      #1;

      // reset with toggling input valid
      for (int i = 0; i < 4; i++) begin
         drive(((i % 2) == 0), 16'hA5A5, 1'b0, 5'd8);
         #1;
         check("rst_val_o", 32'(vout), 32'd0);
         check("rst_count_o", 32'(cnt_out), 32'd0);
         check("rst_ready_o", 32'(rdy_out), 32'd0);
         check("rst_data_o", 32'(dout), 32'd0);
         step();
      end
      drive(1'b0, '0, 1'b0, '0);
      rst_n = 1'b1;
      #1;
      check("ready_after_release", 32'(rdy_out), 32'd1);

      // single beat, mode 0 then mode 1
      for (int m = 0; m < 2; m++) begin
         drive(1'b1, 16'hF0F3, m[0], (m == 0) ? 5'd10 : 5'd6);
         step();
         drive(1'b0, '0, 1'b0, '0);
         for (int k = 1; k <= 4; k++) begin
            check("single_latency_val", 32'(vout), 32'(k == 4));
            if (k < 4) step();
         end
         check("single_count", 32'(cnt_out), (m == 0) ? 32'd10 : 32'd6);
         check("single_data", 32'(dout), 32'hF0F3);
         check("single_mode", 32'(mode_out), 32'(m));
         step();
         check("single_idle", 32'(vout), 32'd0);
      end

      // streaming, full pipe with same-cycle accept and emit
      for (int k = 1; k <= 9; k++) begin
         if (k <= 6) begin
            drive(1'b1, s_w[k-1], s_m[k-1], s_c[k-1]);
            check("stream_ready", 32'(rdy_out), 32'd1);
         end else begin
            drive(1'b0, '0, 1'b0, '0);
         end
         step();
         if (k >= 4) begin
            check("stream_val", 32'(vout), 32'd1);
            check("stream_count", 32'(cnt_out), 32'(s_c[k-4]));
         end
      end
      drive(1'b0, '0, 1'b0, '0);
      step();
      check("stream_empty", 32'(vout), 32'd0);

      // backpressure: 10 stalled cycles of continuous input
      rdy_in = 1'b0;
      #1;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (c >= 4) begin
            check("stall_val", 32'(vout), 32'd1);
            check("stall_data", 32'(dout), 32'(bp_w[0]));
            check("stall_count", 32'(cnt_out), 32'(bp_c[0]));
            check("stall_ready", 32'(rdy_out), 32'd0);
         end
         drive(1'b1, bp_w[idx], bp_m[idx], bp_c[idx]);
         took = rdy_out;
         step();
         if (took && idx < 8) idx++;
      end
      check("stall_accepted", 32'(idx), 32'd4);
      drive(1'b0, '0, 1'b0, '0);
      rdy_in = 1'b1;
      n = emitted;
      for (int c = 0; c < 6; c++) step();
      check("drain_count", 32'(emitted - n), 32'd4);
      check("drain_queue", 32'(exp_q.size()), 32'd0);

      // backpressure with a bubble at the input: it collapses while stalled
      rdy_in = 1'b0;
      #1;
      idx = 4;
      for (int c = 0; c < 10; c++) begin
         if (c >= 5) begin
            check("bubble_stall_data", 32'(dout), 32'(bp_w[4]));
            check("bubble_stall_count", 32'(cnt_out), 32'(bp_c[4]));
            check("bubble_stall_ready", 32'(rdy_out), 32'd0);
         end
         v = (c != 1);
         drive(v, bp_w[idx], bp_m[idx], bp_c[idx]);
         took = v & rdy_out;
         step();
         if (took && idx < 8) idx++;
      end
      check("bubble_accepted", 32'(idx - 4), 32'd4);
      drive(1'b0, '0, 1'b0, '0);
      rdy_in = 1'b1;
      n = emitted;
      for (int c = 0; c < 6; c++) step();
      check("bubble_drain_count", 32'(emitted - n), 32'd4);
      check("bubble_drain_queue", 32'(exp_q.size()), 32'd0);

      // reset mid-flight with three beats inside
      rdy_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, bp_w[c], bp_m[c], bp_c[c]);
         step();
      end
      drive(1'b0, '0, 1'b0, '0);
      step();
      check("pre_rst_val", 32'(vout), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_val", 32'(vout), 32'd0);
      check("rst_async_ready", 32'(rdy_out), 32'd0);
      exp_q.delete();
      em_base = emitted;
      step();
      step();
      rst_n = 1'b1;
      rdy_in = 1'b1;
      n = emitted;
      for (int c = 0; c < 8; c++) step();
      check("post_rst_no_stale", 32'(emitted - n), 32'd0);

      // uneven slicing, WIDTH=10 STAGES=4 (CHUNK=3)
      d10 = 10'h3FF; m10 = 1'b0; v10 = 1'b1;
      step();
      v10 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check("w10_latency_val", 32'(vo10), 32'(k == 4));
         if (k < 4) step();
      end
      check("w10_count_ones", 32'(c10), 32'd10);
      check("w10_data", 32'(do10), 32'h3FF);
      step();
      d10 = 10'h001; m10 = 1'b1; v10 = 1'b1;
      step();
      v10 = 1'b0;
      for (int k = 2; k <= 4; k++) step();
      check("w10_zero_val", 32'(vo10), 32'd1);
      check("w10_count_zeros", 32'(c10), 32'd9);
      step();

      // single stage, WIDTH=10
      ds1 = 10'h2A5; ms1 = 1'b0; vs1 = 1'b1;
      step();
      vs1 = 1'b0;
      check("s1_val", 32'(vos1), 32'd1);
      check("s1_count", 32'(cs1), 32'd5);
      check("s1_data", 32'(dos1), 32'h2A5);
      step();
      check("s1_idle", 32'(vos1), 32'd0);

`ifdef BIT_COUNTER_PIPE_STATS_EN
      check("beats_o", beats, 32'(emitted - em_base));
      check("beats10_o", beats10, 32'd2);
      check("beats1_o", beats1, 32'd1);
`endif

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
